segmented_modulator: RTL and testbench
======================================

Name: segmented_modulator

Overview:
- Next-generation amplitude modulator for the transducer pipeline, placed between the duty/phase generator and the PWM stage.
- Owns two independent modulation segments, each with its own cycle length and sampling divider.
- Switches between segments glitch-free at the segment wrap boundary.
- Applies per-channel sample delay and scales DUTY_IN by the fetched modulation sample in a fixed-latency pipeline.

Parameters:
- WIDTH, 13, duty/phase bit width
- DEPTH, 249, channels per frame
- MOD_WIDTH, 8, modulation sample width
- ADDR_WIDTH, 15, sample index width per segment

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- SYNC  in  1  one-cycle pulse; restarts sampling at index 0
- CYCLE_M0, CYCLE_M1  in  16  last sample index of segment 0/1; bits above ADDR_WIDTH ignored
- FREQ_DIV_M0, FREQ_DIV_M1  in  32  CLK cycles per sample for segment 0/1; 0 treated as 1
- SEG_REQ  in  1  requested segment
- SEG_REQ_VALID  in  1  request strobe
- DIN_VALID  in  1  channel beat valid
- DUTY_IN  in  WIDTH  channel duty
- PHASE_IN  in  WIDTH  channel phase
- DELAY_M[DEPTH]  in  16 each  per-channel delay in samples
- MEM_ADDR  out  ADDR_WIDTH+1  {segment, sample index}; modulation RAM read address
- MEM_DATA  in  MOD_WIDTH  RAM read data, 2-cycle latency from MEM_ADDR
- DUTY_OUT  out  WIDTH  modulated duty
- PHASE_OUT  out  WIDTH  phase, delayed to align with DUTY_OUT
- DOUT_VALID  out  1  output beat valid
- IDX  out  16  current sample index, zero-extended
- SEGMENT  out  1  active segment

Behaviour:
- Reset clears all state. DUTY_OUT=0, PHASE_OUT=0, DOUT_VALID=0, IDX=0, SEGMENT=0, MEM_ADDR=0; pending request cleared; channel counter=0.
- RST asserted mid-frame discards in-flight beats. DOUT_VALID=0 from the next cycle.
- Sampler: div_cnt counts 0..FREQ_DIV_seg-1. When div_cnt wraps, IDX increments. IDX wraps to 0 after reaching CYCLE_M_seg.
- SYNC sets div_cnt=0 and IDX=0 on the next cycle.
- Segment switch:
  - SEG_REQ_VALID latches SEG_REQ as pending. A newer request overwrites an older one.
  - A request equal to the active segment clears pending.
  - The pending segment becomes active in the same cycle that IDX wraps to 0. The new segment's CYCLE/FREQ_DIV apply from that cycle on.
  - SYNC together with a pending or same-cycle request activates it immediately, with IDX=0.
- If CYCLE_M changes while IDX exceeds the new value, IDX wraps to 0 on the next sample tick.
- Frame handling:
  - Channel counter ch increments on each DIN_VALID beat and wraps from DEPTH-1 to 0. It holds when DIN_VALID is low.
  - At the ch=0 beat, IDX, SEGMENT and CYCLE_M_seg are snapshotted and used for the whole frame.
- Address (cycle t+1): d = min(DELAY_M[ch], cyc). idx_i = idx_snap-d if idx_snap>=d, else idx_snap+cyc+1-d. MEM_ADDR = {seg_snap, idx_i}.
- Multiply (cycle t+4):
  - If M=MEM_DATA is 0, DUTY_OUT=0.
  - Otherwise DUTY_OUT = (DUTY_IN*(M+1)) >> MOD_WIDTH. Product width is WIDTH+MOD_WIDTH+1; result truncated to WIDTH.
- Latency: a beat at cycle t gives DUTY_OUT/PHASE_OUT/DOUT_VALID at t+4. Back-to-back beats give full throughput. PHASE_IN and DUTY_IN travel through matching delay registers.
- When DOUT_VALID=0, DUTY_OUT and PHASE_OUT hold their last values.

Optional Feature:
- SEGMENTED_MODULATOR_DELAY_EN defined: per-channel delay applied as described above.
- Undefined: DELAY_M is ignored (d=0 for all channels) and the subtract/compare logic is removed. Latency stays 4 cycles.

Test Plan:
- FREQ_DIV_M0=4, CYCLE_M0=3, SYNC pulse -> IDX runs 0,1,2,3,0, changing every 4 CLK; SEGMENT=0.
- CYCLE_M0=7, CYCLE_M1=2, SEG_REQ=1 strobed at IDX=3 -> SEGMENT stays 0 until IDX wraps 7->0, then becomes 1; IDX then runs 0,1,2,0. Same test with SYNC in the strobe cycle -> switch happens immediately.
- Modulation RAM model returns M=255/127/0, DUTY_IN=4096 -> DUTY_OUT=4096/2048/0, each appearing 4 cycles after its DIN_VALID beat.
- DELAY_EN defined, idx_snap=2, cyc=7, DELAY_M[5]=4 -> MEM_ADDR for ch5 = 6. DELAY_M[6]=100 -> d=7, addr=3. DELAY_EN undefined -> both give addr 2.
- DEPTH continuous beats, with IDX advancing mid-frame -> every beat of the frame uses the snapshotted IDX; DOUT_VALID count=DEPTH; PHASE_OUT equals PHASE_IN delayed by 4.
- RST asserted for 1 cycle in the middle of a frame -> DOUT_VALID=0 next cycle, outputs 0; the next DIN_VALID beat is treated as ch=0.

Source files
------------

// File: rtl/segmented_modulator.sv
// Two-segment amplitude modulator: sample sequencer, per-frame snapshot, RAM addressing and duty scaling.
// Define SEGMENTED_MODULATOR_DELAY_EN to enable the per-channel sample delay.
module segmented_modulator #(
    parameter int unsigned WIDTH      = 13,
    parameter int unsigned DEPTH      = 249,
    parameter int unsigned MOD_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sync_i,
    input  logic [15:0]           cycle_m0_i,
    input  logic [15:0]           cycle_m1_i,
    input  logic [31:0]           freq_div_m0_i,
    input  logic [31:0]           freq_div_m1_i,
    input  logic                  seg_req_i,
    input  logic                  seg_req_valid_i,
    input  logic                  din_valid_i,
    input  logic [WIDTH-1:0]      duty_i,
    input  logic [WIDTH-1:0]      phase_i,
    input  logic [15:0]           delay_m_i [DEPTH],
    output logic [ADDR_WIDTH:0]   mem_addr_o,
    input  logic [MOD_WIDTH-1:0]  mem_data_i,
    output logic [WIDTH-1:0]      duty_o,
    output logic [WIDTH-1:0]      phase_o,
    output logic                  dout_valid_o,
    output logic [15:0]           idx_o,
    output logic                  segment_o
);
    localparam int unsigned AW     = ADDR_WIDTH;
    localparam int unsigned CH_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PROD_W = WIDTH + MOD_WIDTH + 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(DEPTH - 1);

    logic [31:0]          div_q, div_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic                 seg_q, seg_d;
    logic                 pend_v_q, pend_v_d, pend_s_q, pend_s_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [AW-1:0]        idx_snap_q;
    logic                 seg_snap_q;
    logic [AW:0]          mem_addr_q;
    logic                 v1_q, v2_q, v3_q;
    logic [WIDTH-1:0]     d1_q, d2_q, d3_q, p1_q, p2_q, p3_q;
    logic [WIDTH-1:0]     duty_q, phase_q;
    logic                 dout_valid_q;

    logic [AW-1:0]        cyc_c;
    logic [31:0]          div_last_c;
    logic                 pend_v_c, pend_s_c;
    logic                 first_c;
    logic [AW-1:0]        idx_s_c;
    logic                 seg_s_c;
    logic [AW-1:0]        addr_idx_c;
    logic [MOD_WIDTH:0]   m_inc_c;
    logic [PROD_W-1:0]    prod_c;
    logic [WIDTH-1:0]     scaled_c;

    logic unused_cyc_c;
    assign unused_cyc_c = ^{cycle_m0_i[15:AW], cycle_m1_i[15:AW]};

    // Sampler and segment switch; a pending switch only lands on an index wrap or SYNC.
    always_comb begin
        cyc_c      = seg_q ? cycle_m1_i[AW-1:0] : cycle_m0_i[AW-1:0];
        div_last_c = seg_q ? freq_div_m1_i : freq_div_m0_i;
        if (div_last_c != 32'd0) div_last_c = div_last_c - 32'd1;

        pend_v_c = pend_v_q;
        pend_s_c = pend_s_q;
        if (seg_req_valid_i) begin
            pend_s_c = seg_req_i;
            pend_v_c = (seg_req_i != seg_q);
        end

        div_d    = div_q;
        idx_d    = idx_q;
        seg_d    = seg_q;
        pend_v_d = pend_v_c;
        pend_s_d = pend_s_c;
        if (sync_i) begin
            div_d    = '0;
            idx_d    = '0;
            seg_d    = pend_v_c ? pend_s_c : seg_q;
            pend_v_d = 1'b0;
        end else if (div_q >= div_last_c) begin
            div_d = '0;
            if (idx_q >= cyc_c) begin
                idx_d    = '0;
                seg_d    = pend_v_c ? pend_s_c : seg_q;
                pend_v_d = 1'b0;
            end else begin
                idx_d = idx_q + AW'(1);
            end
        end else begin
            div_d = div_q + 32'd1;
        end
    end

    // Channel counter; the ch=0 beat uses live sampler state, later beats the snapshot.
    always_comb begin
        first_c = (ch_q == '0);
        idx_s_c = first_c ? idx_q : idx_snap_q;
        seg_s_c = first_c ? seg_q : seg_snap_q;
        ch_d    = ch_q;
        if (din_valid_i) ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
    end

`ifdef SEGMENTED_MODULATOR_DELAY_EN
    logic [AW-1:0] cyc_snap_q;
    logic [AW-1:0] cyc_s_c;
    logic [AW-1:0] dly_c;
    logic [15:0]   dly_raw_c;

    always_comb begin
        cyc_s_c   = first_c ? cyc_c : cyc_snap_q;
        dly_raw_c = delay_m_i[ch_q];
        dly_c     = (dly_raw_c > 16'(cyc_s_c)) ? cyc_s_c : AW'(dly_raw_c);
        if (idx_s_c >= dly_c) begin
            addr_idx_c = idx_s_c - dly_c;
        end else begin
            addr_idx_c = AW'((AW+1)'(idx_s_c) + (AW+1)'(cyc_s_c) + (AW+1)'(1) - (AW+1)'(dly_c));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_snap_q <= '0;
        end else if (din_valid_i && first_c) begin
            cyc_snap_q <= cyc_c;
        end
    end
`else
    logic unused_delay_c;
    always_comb begin
        addr_idx_c     = idx_s_c;
        unused_delay_c = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) unused_delay_c = unused_delay_c ^ (^delay_m_i[i]);
    end
`endif

    // A zero sample forces silence; otherwise scale by (M+1)/2^MOD_WIDTH.
    always_comb begin
        m_inc_c  = (MOD_WIDTH+1)'(mem_data_i) + (MOD_WIDTH+1)'(1);
        prod_c   = PROD_W'(d3_q) * PROD_W'(m_inc_c);
        scaled_c = (mem_data_i == '0) ? '0 : WIDTH'(prod_c >> MOD_WIDTH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q        <= '0;
            idx_q        <= '0;
            seg_q        <= 1'b0;
            pend_v_q     <= 1'b0;
            pend_s_q     <= 1'b0;
            ch_q         <= '0;
            idx_snap_q   <= '0;
            seg_snap_q   <= 1'b0;
            mem_addr_q   <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            d1_q         <= '0;
            d2_q         <= '0;
            d3_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            p3_q         <= '0;
            duty_q       <= '0;
            phase_q      <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            pend_v_q <= pend_v_d;
            pend_s_q <= pend_s_d;
            ch_q     <= ch_d;
            if (din_valid_i) begin
                mem_addr_q <= {seg_s_c, addr_idx_c};
                if (first_c) begin
                    idx_snap_q <= idx_q;
                    seg_snap_q <= seg_q;
                end
            end
            v1_q <= din_valid_i;
            v2_q <= v1_q;
            v3_q <= v2_q;
            d1_q <= duty_i;
            d2_q <= d1_q;
            d3_q <= d2_q;
            p1_q <= phase_i;
            p2_q <= p1_q;
            p3_q <= p2_q;
            dout_valid_q <= v3_q;
            if (v3_q) begin
                duty_q  <= scaled_c;
                phase_q <= p3_q;
            end
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign duty_o       = duty_q;
    assign phase_o      = phase_q;
    assign dout_valid_o = dout_valid_q;
    assign idx_o        = 16'(idx_q);
    assign segment_o    = seg_q;

endmodule

// File: tb/tb_segmented_modulator.sv
// Directed self-checking bench for segmented_modulator with a 2-cycle-latency modulation RAM model.
module tb_segmented_modulator;
    localparam int DEPTH = 249;

    logic        clk;
    logic        rst;
    logic        sync;
    logic [15:0] cyc0, cyc1;
    logic [31:0] fd0, fd1;
    logic        seg_req, seg_req_valid, din_valid;
    logic [12:0] duty, phase;
    logic [15:0] delay_m [DEPTH];
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [12:0] duty_out, phase_out;
    logic        dout_valid;
    logic [15:0] idx;
    logic        segment;

    logic [7:0]  ram [65536];
    logic [15:0] ra1, ra2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [12:0] duty;
        logic [12:0] phase;
        logic [7:0]  m;
        logic [12:0] exp_duty;
    } vec_t;
    vec_t vecs [6];

    segmented_modulator dut (
        .clk_i(clk), .rst_i(rst), .sync_i(sync),
        .cycle_m0_i(cyc0), .cycle_m1_i(cyc1),
        .freq_div_m0_i(fd0), .freq_div_m1_i(fd1),
        .seg_req_i(seg_req), .seg_req_valid_i(seg_req_valid),
        .din_valid_i(din_valid), .duty_i(duty), .phase_i(phase),
        .delay_m_i(delay_m), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
        .duty_o(duty_out), .phase_o(phase_out), .dout_valid_o(dout_valid),
        .idx_o(idx), .segment_o(segment)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ra1 <= mem_addr;
        ra2 <= ra1;
    end
    assign mem_data = ram[ra2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_idx [8];
        int exp_seg [8];
        logic [15:0] addrs [7];
        int vcount;
        int bj, dj, ex;

        vecs[0] = '{13'd4096, 13'h111, 8'd255, 13'd4096};
        vecs[1] = '{13'd4096, 13'h222, 8'd127, 13'd2048};
        vecs[2] = '{13'd4096, 13'h333, 8'd0,   13'd0};
        vecs[3] = '{13'd8191, 13'h1FFF, 8'd255, 13'd8191};
        vecs[4] = '{13'd1000, 13'h000, 8'd100, 13'd394};
        vecs[5] = '{13'd8191, 13'h0AA, 8'd200, 13'd6431};
        exp_idx = '{4, 5, 6, 7, 0, 1, 2, 0};
        exp_seg = '{0, 0, 0, 0, 1, 1, 1, 1};

        rst = 1'b1; sync = 1'b0; cyc0 = 16'd3; cyc1 = 16'd2; fd0 = 32'd4; fd1 = 32'd1;
        seg_req = 1'b0; seg_req_valid = 1'b0; din_valid = 1'b0; duty = '0; phase = '0;
        for (int i = 0; i < DEPTH; i++) delay_m[i] = 16'd0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'hFF;

        // Reset state
        repeat (2) step();
        check("rst_duty", duty_out, 0);
        check("rst_phase", phase_out, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_idx", idx, 0);
        check("rst_seg", segment, 0);
        check("rst_addr", mem_addr, 0);
        rst = 1'b0;

        // Sampler: divider 4, cycle 3
        sync = 1'b1; step(); sync = 1'b0;
        for (int j = 0; j < 20; j++) begin
            check("sampler_idx", idx, 32'((j / 4) % 4));
            step();
        end
        check("sampler_seg", segment, 0);

        // Segment switch deferred to wrap
        cyc0 = 16'd7; fd0 = 32'd1;
        sync = 1'b1; step(); sync = 1'b0;
        repeat (3) step();
        check("switch_pre_idx", idx, 3);
        seg_req = 1'b1; seg_req_valid = 1'b1; step(); seg_req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("switch_idx", idx, 32'(exp_idx[i]));
            check("switch_seg", segment, 32'(exp_seg[i]));
            step();
        end

        // Segment switch with SYNC in the strobe cycle
        seg_req = 1'b0; seg_req_valid = 1'b1; sync = 1'b1; step();
        seg_req_valid = 1'b0; sync = 1'b0;
        check("syncsw_idx", idx, 0);
        check("syncsw_seg", segment, 0);
        repeat (7) step();
        check("syncsw_idx7", idx, 7);
        step();
        check("syncsw_wrap", idx, 0);
        check("syncsw_seg_hold", segment, 0);

        // Multiply vectors, one isolated beat each
        fd0 = 32'hFFFF_FFFF;
        sync = 1'b1; step(); sync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ram[0] = vecs[i].m;
            duty = vecs[i].duty; phase = vecs[i].phase; din_valid = 1'b1;
            step();
            din_valid = 1'b0;
            repeat (2) step();
            check("mul_early_valid", dout_valid, 0);
            step();
            check("mul_valid", dout_valid, 1);
            check("mul_duty", duty_out, vecs[i].exp_duty);
            check("mul_phase", phase_out, vecs[i].phase);
            step();
        end
        check("hold_valid", dout_valid, 0);
        check("hold_duty", duty_out, vecs[5].exp_duty);
        check("hold_phase", phase_out, vecs[5].phase);

        // Address generation with idx_snap=2, cyc=7
        rst = 1'b1; step(); rst = 1'b0;
        cyc0 = 16'd7; fd0 = 32'd1;
        sync = 1'b1; step(); sync = 1'b0;
        repeat (2) step();
        fd0 = 32'hFFFF_FFFF;
        delay_m[5] = 16'd4; delay_m[6] = 16'd100;
        for (int c = 0; c < 7; c++) begin
            din_valid = 1'b1;
            step();
            addrs[c] = mem_addr;
        end
        din_valid = 1'b0;
        check("addr_ch0", addrs[0], 2);
        check("addr_ch4", addrs[4], 2);
`ifdef SEGMENTED_MODULATOR_DELAY_EN
        check("addr_ch5", addrs[5], 6);
        check("addr_ch6", addrs[6], 3);
`else
        check("addr_ch5", addrs[5], 2);
        check("addr_ch6", addrs[6], 2);
`endif
        delay_m[5] = 16'd0; delay_m[6] = 16'd0;

        // Full frame with IDX advancing mid-frame; snapshot idx=1
        rst = 1'b1; step(); rst = 1'b0;
        cyc0 = 16'd7; fd0 = 32'd3;
        for (int i = 0; i < 8; i++) ram[i] = 8'(40 * i + 15);
        sync = 1'b1; step(); sync = 1'b0;
        repeat (4) step();
        vcount = 0;
        for (int j = 0; j < DEPTH + 3; j++) begin
            din_valid = (j < DEPTH);
            duty  = 13'((j * 37) % 8192);
            phase = 13'((j * 53 + 7) % 8192);
            step();
            if (dout_valid) vcount++;
            if (j >= 3) begin
                bj = j - 3;
                dj = (bj * 37) % 8192;
                ex = (dj * 56) >> 8;
                check("frame_valid", dout_valid, 1);
                check("frame_duty", duty_out, 32'(ex));
                check("frame_phase", phase_out, 32'((bj * 53 + 7) % 8192));
            end
        end
        din_valid = 1'b0;
        step();
        if (dout_valid) vcount++;
        check("frame_valid_count", vcount, DEPTH);

        // Reset in the middle of a frame
        sync = 1'b1; step(); sync = 1'b0;
        for (int j = 0; j < 10; j++) begin
            din_valid = 1'b1; duty = 13'd4096; phase = 13'(j + 1);
            step();
        end
        din_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_valid", dout_valid, 0);
        check("midrst_duty", duty_out, 0);
        check("midrst_phase", phase_out, 0);
        check("midrst_idx", idx, 0);
        check("midrst_seg", segment, 0);
        step();
        check("midrst_flush1", dout_valid, 0);
        step();
        check("midrst_flush2", dout_valid, 0);
        repeat (5) step();
        din_valid = 1'b1; duty = 13'd4096; phase = 13'h0ABC;
        step();
        din_valid = 1'b0;
        repeat (3) step();
        check("postrst_valid", dout_valid, 1);
        check("postrst_duty", duty_out, 1536);
        check("postrst_phase", phase_out, 13'h0ABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
